// File: rtl/dm_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_bus_pkg
// Description : Shared state encoding and byte-enable constants for the
//               M-stage data-bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BYTEEN_NONE = 4'b0000;
   localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/dm_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_bus_ctrl_if
// Description : M-stage request/stall signals plus external req/ack data bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_bus_ctrl_if;

   logic        m_valid;
   logic        m_re;
   logic [3:0]  m_byteen;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        stall_m;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        exc_timeout;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_byteen;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   // Controller side.
   modport master (
      input  m_valid, m_re, m_byteen, m_addr, m_wdata, bus_ack, bus_rdata,
      output stall_m, rdata, rdata_valid, exc_timeout,
             bus_req, bus_we, bus_addr, bus_byteen, bus_wdata
   );

   // Pipeline and memory side.
   modport slave (
      output m_valid, m_re, m_byteen, m_addr, m_wdata, bus_ack, bus_rdata,
      input  stall_m, rdata, rdata_valid, exc_timeout,
             bus_req, bus_we, bus_addr, bus_byteen, bus_wdata
   );

endinterface
`default_nettype wire

// File: rtl/dm_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : dm_bus_timer
// Description : Bus wait counter; flags expiry on its TIMEOUT-th counted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_bus_timer #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dm_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_bus_ctrl
// Description : M-stage data-bus controller: req/ack transaction, pipeline
//               stall, raw read-word capture and bounded-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_bus_ctrl
   import dm_bus_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 10
) (
   input  logic          clk,
   input  logic          reset,
   dm_bus_ctrl_if.master dbus
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_go;
   logic        w_is_write;
   logic        w_stall;
   logic        w_tmr_clr;
   logic        w_tmr_en;
   logic        w_expired;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_byteen;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_timed_out;

   assign w_is_write = (dbus.m_byteen != BYTEEN_NONE);
   assign w_go       = dbus.m_valid & (dbus.m_re | w_is_write);

   dm_bus_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_tmr_clr   = 1'b0;
      w_tmr_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_stall = w_go;
            if (w_go) begin
               w_tmr_clr   = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_stall  = 1'b1;
            w_tmr_en = 1'b1;
            if (dbus.bus_ack || w_expired) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // The same instruction is still presented here, so never re-accept.
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_byteen    <= BYTEEN_NONE;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_timed_out <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (w_go) begin
            r_we        <= w_is_write;
            r_addr      <= dbus.m_addr & ~32'h0000_0003;
            r_byteen    <= w_is_write ? dbus.m_byteen : BYTEEN_WORD;
            r_wdata     <= dbus.m_wdata;
            r_timed_out <= 1'b0;
         end
      end else if (r_state == ST_BUSY) begin
         // Ack takes priority over a coincident expiry.
         if (dbus.bus_ack) begin
            if (!r_we) begin
               r_rdata <= dbus.bus_rdata;
            end
         end else if (w_expired) begin
            r_rdata     <= '0;
            r_timed_out <= 1'b1;
         end
      end
   end

   assign dbus.stall_m     = w_stall & ~reset;
   assign dbus.bus_req     = (r_state == ST_BUSY);
   assign dbus.bus_we      = r_we;
   assign dbus.bus_addr    = r_addr;
   assign dbus.bus_byteen  = r_byteen;
   assign dbus.bus_wdata   = r_wdata;
   assign dbus.rdata       = r_rdata;
   assign dbus.rdata_valid = (r_state == ST_DONE) & ~r_we;
   assign dbus.exc_timeout = (r_state == ST_DONE) & r_timed_out;

endmodule
`default_nettype wire

// File: doc/dm_bus_ctrl.md
Name: dm_bus_ctrl

Overview:
- Memory-stage bus controller in the P6 pipeline.
- Takes the M-stage access request (word address, byte enables, write data already lane-shifted by the data-memory alignment logic) and runs a req/ack transaction on the external data bus.
- Stalls the pipeline while the transaction is outstanding and returns the raw 32-bit bus word, which feeds the load-extension logic.
- Provides a bounded-wait timeout with an exception flag.

Parameters:
- TIMEOUT, 64, number of cycles waited for bus_ack before the access is abandoned (legal range 2..1023).
- CNT_W, 10, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- m_valid  input  1  M stage holds a valid instruction.
- m_re  input  1  instruction is a load (lw/lh/lhu/lb/lbu).
- m_byteen  input  4  store byte enables; 4'b0000 means no store.
- m_addr  input  32  byte address from the ALU.
- m_wdata  input  32  lane-shifted store data.
- stall_m  output  1  freeze F/D/E/M registers this cycle.
- rdata  output  32  captured bus word; valid when rdata_valid=1.
- rdata_valid  output  1  rdata holds the result of the current M-stage load.
- exc_timeout  output  1  one-cycle pulse: the access was abandoned.
- bus_req  output  1  transaction request.
- bus_we  output  1  1 = write, 0 = read.
- bus_addr  output  32  word-aligned address, {m_addr[31:2],2'b00}.
- bus_byteen  output  4  latched byte enables; 4'b1111 on reads.
- bus_wdata  output  32  latched store data.
- bus_ack  input  1  slave completes the transaction this cycle; bus_rdata is valid with it.
- bus_rdata  input  32  read data.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; the counter clears.
  - All outputs go to 0: stall_m, rdata, rdata_valid, exc_timeout, bus_req, bus_we, bus_addr, bus_byteen, bus_wdata.
- Access detection: go = m_valid & (m_re | (m_byteen != 4'b0000)). A request with both m_re=1 and a nonzero byte enable is treated as a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall_m = go, combinationally.
  - If go, latch addr/byteen/wdata/we and go to BUSY.
  - bus_req rises on the next clock edge; it is registered, so the latency from go to bus_req is 1 cycle.
- BUSY:
  - bus_req=1; bus_* stay constant; stall_m=1; the counter increments each cycle.
  - On bus_ack: capture bus_rdata into rdata (reads only; writes leave rdata unchanged), drop bus_req on the next edge, go to DONE.
  - On counter==TIMEOUT-1 with no ack: drop bus_req, set rdata=0, pulse exc_timeout in the DONE cycle, go to DONE.
  - bus_ack and timeout in the same cycle: the ack wins and no exception is raised.
- DONE:
  - stall_m=0, so the pipeline advances at the end of this cycle.
  - rdata_valid=1 if the access was a read; exc_timeout is high only if the access timed out.
  - Always return to IDLE. A new go is never accepted in DONE, because the same M-stage instruction is still presented.
- Cost and throughput:
  - Minimum cost of an access is 3 cycles (IDLE detect, BUSY with an immediate ack, DONE).
  - Back-to-back accesses go DONE→IDLE→BUSY, one access per 3 cycles at best.
- bus_ack outside BUSY is ignored. No state change and no data capture occur.
- m_* inputs are sampled only in IDLE; changes during BUSY are ignored.
- Reset asserted mid-BUSY drops bus_req immediately (asynchronously) with no completion. The slave must tolerate a withdrawn request.
- The counter clears on entry to BUSY. CNT_W-bit arithmetic never wraps because TIMEOUT < 2^CNT_W.

Decomposition:
- Shared package dm_bus_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - BYTEEN_NONE=4'b0000 and BYTEEN_WORD=4'b1111.
- Sub-module dm_bus_timer is natural: a CNT_W counter with clear/enable inputs and an expired output at TIMEOUT-1.
- The FSM, request latches and rdata capture stay in dm_bus_ctrl.

Test Plan:
- Load with immediate ack:
  - Stimulus: m_valid=1, m_re=1, m_addr=0x0000_1006; ack asserted in the first BUSY cycle with bus_rdata=0xA1B2_C3D4.
  - Required: bus_addr=0x0000_1004, bus_byteen=4'b1111, bus_we=0.
  - Required: stall_m high for 2 cycles, then rdata=0xA1B2_C3D4 with rdata_valid=1 in DONE.
- Byte store with slow ack:
  - Stimulus: m_byteen=4'b0100, m_wdata=0x00EE_0000; ack after 5 BUSY cycles.
  - Required: bus_we=1, bus_byteen=4'b0100, bus_req high for exactly 5 cycles, stall_m high for 6 cycles, rdata_valid=0 in DONE.
- Timeout with TIMEOUT=4:
  - Stimulus: read, never acked.
  - Required: bus_req high for 4 cycles; DONE follows with exc_timeout=1 for 1 cycle, rdata=0, stall_m=0.
- Ack/timeout tie:
  - Stimulus: ack on cycle TIMEOUT-1 of BUSY.
  - Required: exc_timeout=0 and rdata=bus_rdata.
- Spurious ack and changing inputs:
  - Stimulus: bus_ack pulsed in IDLE; m_addr changed mid-BUSY.
  - Required: no state change on the spurious ack; bus_addr stays at the latched value.
- Asynchronous reset mid-BUSY:
  - Stimulus: reset raised between clock edges during BUSY.
  - Required: bus_req and stall_m fall immediately; after release the FSM is in IDLE and a new load completes normally.
